// File: rtl/xadc_drp_pkg.sv
// Shared DRP widths, FSM state encoding and XADC register addresses for the
// XADC DRP master and its benches.
package xadc_drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    localparam logic [DRP_ADDR_W-1:0] DEF_CH_BASE    = 7'h1c;
    localparam logic [DRP_ADDR_W-1:0] XADC_CFG0_ADDR = 7'h40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT
    } drp_state_t;

    function automatic logic [DRP_ADDR_W-1:0] ch_addr(
        input logic [DRP_ADDR_W-1:0] base,
        input logic [3:0]            ch
    );
        return base + DRP_ADDR_W'(ch);
    endfunction

endpackage

// File: rtl/xadc_drp_timer.sv
// Loadable down-counter bounding one DRP transaction; expired is high once an
// armed count has reached zero, until the next clear or load.
module drp_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    always_comb begin
        // NOTE: defaults first so every path assigns every _d signal; no latches.
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (clear) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (load) begin
            cnt_d   = load_val;
            armed_d = 1'b1;
        end else if (armed_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments; combinational logic above uses blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign expired = armed_q && (cnt_q == '0);

endmodule

// File: rtl/xadc_drp_master.sv
// XADC DRP initiator: sweeps channel status registers on each eoc edge,
// interleaves single configuration writes, and bounds every transaction.
module xadc_drp_master
    import xadc_drp_pkg::*;
#(
    parameter int                    NUM_CH  = 4,
    parameter logic [DRP_ADDR_W-1:0] CH_BASE = DEF_CH_BASE,
    parameter int                    TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         eoc_in,
    output logic                         den_out,
    output logic                         dwe_out,
    output logic [DRP_ADDR_W-1:0]        daddr_out,
    output logic [DRP_DATA_W-1:0]        di_out,
    input  logic                         drdy_in,
    input  logic [DRP_DATA_W-1:0]        do_in,
    input  logic                         wr_req,
    input  logic [DRP_ADDR_W-1:0]        wr_addr,
    input  logic [DRP_DATA_W-1:0]        wr_data,
    output logic                         wr_ack,
    output logic [DRP_DATA_W*NUM_CH-1:0] ch_data,
    output logic                         ch_valid,
    output logic [3:0]                   ch_idx,
    output logic                         sweep_done,
    input  logic                         clear_err,
    output logic                         timeout_err,
    output logic                         overrun_err
);

    localparam int         CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

    drp_state_t                   state_q, state_d;
    logic [3:0]                   ch_q, ch_d, ch_next;
    logic                         eoc_q, eoc_d, eoc_edge;
    logic                         sweep_pend_q, sweep_pend_d, pend_take;
    logic                         den_q, den_d, dwe_q, dwe_d;
    logic [DRP_ADDR_W-1:0]        daddr_q, daddr_d;
    logic [DRP_DATA_W-1:0]        di_q, di_d;
    logic                         wr_ack_q, wr_ack_d;
    logic                         ch_valid_q, ch_valid_d;
    logic [3:0]                   ch_idx_q, ch_idx_d;
    logic                         sweep_done_q, sweep_done_d;
    logic [DRP_DATA_W*NUM_CH-1:0] ch_data_q, ch_data_d;
    logic                         timeout_err_q, timeout_err_d;
    logic                         overrun_err_q, overrun_err_d;
    logic                         timeout_set, overrun_set;
    logic                         timer_load, timer_clear, timer_expired, xact_end;

    drp_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .clear    (timer_clear),
        .load_val (CNT_W'(TIMEOUT - 1)),
        .expired  (timer_expired)
    );

    assign eoc_edge = eoc_in & ~eoc_q;
    assign xact_end = drdy_in | timer_expired;
    assign ch_next  = ch_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        eoc_d        = eoc_in;
        den_d        = 1'b0;
        dwe_d        = 1'b0;
        daddr_d      = daddr_q;
        di_d         = di_q;
        wr_ack_d     = 1'b0;
        ch_valid_d   = 1'b0;
        ch_idx_d     = ch_idx_q;
        sweep_done_d = 1'b0;
        ch_data_d    = ch_data_q;
        pend_take    = 1'b0;
        timeout_set  = 1'b0;
        timer_load   = 1'b0;
        timer_clear  = 1'b0;

        // den/dwe/daddr are asserted on entry to a REQ state so the strobe
        // leaves a flop in the same cycle the FSM is in that state.
        unique case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    daddr_d = wr_addr;
                    di_d    = wr_data;
                    state_d = ST_WR_REQ;
                end else if (sweep_pend_q) begin
                    pend_take = 1'b1;
                    ch_d      = 4'd0;
                    den_d     = 1'b1;
                    daddr_d   = ch_addr(CH_BASE, 4'd0);
                    state_d   = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                timer_load = 1'b1;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (xact_end) begin
                    timer_clear = 1'b1;
                    if (drdy_in) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch_q == 4'(i)) begin
                                ch_data_d[DRP_DATA_W*i +: DRP_DATA_W] = do_in;
                            end
                        end
                        ch_valid_d = 1'b1;
                        ch_idx_d   = ch_q;
                    end else begin
                        timeout_set = 1'b1;
                    end
                    if (ch_q == LAST_CH) begin
                        sweep_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        ch_d    = ch_next;
                        den_d   = 1'b1;
                        daddr_d = ch_addr(CH_BASE, ch_next);
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                timer_load = 1'b1;
                state_d    = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (xact_end) begin
                    timer_clear = 1'b1;
                    wr_ack_d    = 1'b1;
                    timeout_set = ~drdy_in;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An edge landing while the pending request is being consumed starts
        // a fresh request rather than counting as an overrun.
        overrun_set   = eoc_edge & sweep_pend_q & ~pend_take;
        sweep_pend_d  = (sweep_pend_q & ~pend_take) | eoc_edge;
        timeout_err_d = timeout_set | (timeout_err_q & ~clear_err);
        overrun_err_d = overrun_set | (overrun_err_q & ~clear_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ch_q          <= 4'd0;
            eoc_q         <= 1'b0;
            sweep_pend_q  <= 1'b0;
            den_q         <= 1'b0;
            dwe_q         <= 1'b0;
            daddr_q       <= '0;
            di_q          <= '0;
            wr_ack_q      <= 1'b0;
            ch_valid_q    <= 1'b0;
            ch_idx_q      <= 4'd0;
            sweep_done_q  <= 1'b0;
            // NOTE: the result registers are reset too; downstream must never see stale samples after reset.
            ch_data_q     <= '0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            eoc_q         <= eoc_d;
            sweep_pend_q  <= sweep_pend_d;
            den_q         <= den_d;
            dwe_q         <= dwe_d;
            daddr_q       <= daddr_d;
            di_q          <= di_d;
            wr_ack_q      <= wr_ack_d;
            ch_valid_q    <= ch_valid_d;
            ch_idx_q      <= ch_idx_d;
            sweep_done_q  <= sweep_done_d;
            ch_data_q     <= ch_data_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign den_out     = den_q;
    assign dwe_out     = dwe_q;
    assign daddr_out   = daddr_q;
    assign di_out      = di_q;
    assign wr_ack      = wr_ack_q;
    assign ch_valid    = ch_valid_q;
    assign ch_idx      = ch_idx_q;
    assign sweep_done  = sweep_done_q;
    assign ch_data     = ch_data_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_xadc_drp_master.sv
// Bench for xadc_drp_master: a DRP responder with random data and latency,
// a transaction log, and expectations derived from the protocol timing rules.
module tb_xadc_drp_master;
    import xadc_drp_pkg::*;

    localparam int         NUM_CH  = 4;
    localparam int         TIMEOUT = 8;
    localparam logic [6:0] CH_BASE = DEF_CH_BASE;

    logic        clk = 1'b0, reset = 1'b1;
    logic        eoc_in = 1'b0, drdy_in = 1'b0, wr_req = 1'b0, clear_err = 1'b0;
    logic [15:0] do_in = '0, wr_data = '0;
    logic [6:0]  wr_addr = '0;
    logic        den_out, dwe_out, wr_ack, ch_valid, sweep_done, timeout_err, overrun_err;
    logic [6:0]  daddr_out;
    logic [15:0] di_out;
    logic [3:0]  ch_idx;
    logic [16*NUM_CH-1:0] ch_data;

    xadc_drp_master #(.NUM_CH(NUM_CH), .CH_BASE(CH_BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .eoc_in(eoc_in),
        .den_out(den_out), .dwe_out(dwe_out), .daddr_out(daddr_out), .di_out(di_out),
        .drdy_in(drdy_in), .do_in(do_in),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_idx(ch_idx), .sweep_done(sweep_done),
        .clear_err(clear_err), .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [6:0] addr; logic we; logic [15:0] di; int lat; } den_ev_t;
    typedef struct { int cyc; int idx; logic [15:0] data; } val_ev_t;

    den_ev_t     den_log[$];
    val_ev_t     val_log[$];
    int          done_log[$];
    int          ack_log[$];
    logic [15:0] resp_mem [128];
    logic [15:0] model_ch [NUM_CH];
    int          fixed_lat = 3;
    logic        silent_en = 1'b0;
    logic [6:0]  silent_addr = '0;
    logic        inject_drdy = 1'b0;
    int          resp_cnt = 0;
    logic [15:0] resp_val = '0;
    int          checks = 0;
    int          failures = 0;

    // Responder and monitor: everything observed/driven on the falling edge.
    always @(negedge clk) begin
        int lat;
        drdy_in = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                drdy_in = 1'b1;
                do_in   = resp_val;
            end
        end
        if (inject_drdy) begin
            drdy_in     = 1'b1;
            do_in       = 16'($urandom);
            inject_drdy = 1'b0;
        end
        if (den_out) begin
            lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
            den_log.push_back('{cyc, daddr_out, dwe_out, di_out, lat});
            if (!(silent_en && !dwe_out && daddr_out == silent_addr)) begin
                resp_cnt = lat;
                resp_val = dwe_out ? 16'h0 : resp_mem[daddr_out];
            end
        end
        if (ch_valid) val_log.push_back('{cyc, int'(ch_idx), ch_data[16*int'(ch_idx) +: 16]});
        if (sweep_done) done_log.push_back(cyc);
        if (wr_ack) ack_log.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        den_log.delete();
        val_log.delete();
        done_log.delete();
        ack_log.delete();
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < NUM_CH; i++) resp_mem[CH_BASE + 7'(i)] = 16'($urandom);
    endtask

    function automatic logic [16*NUM_CH-1:0] model_vec();
        logic [16*NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) v[16*i +: 16] = model_ch[i];
        return v;
    endfunction

    task automatic pulse_eoc(output int t0);
        t0     = cyc;
        eoc_in = 1'b1;
        tick(1);
        eoc_in = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        int seen;
        seen = 0;
        ok   = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sweep_done) seen++;
            if (seen >= n) begin
                ok = 1'b1;
                break;
            end
        end
        tick(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({den_out, dwe_out, wr_ack, ch_valid, sweep_done, timeout_err, overrun_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 0000000",
                     {den_out, dwe_out, wr_ack, ch_valid, sweep_done, timeout_err, overrun_err});
        end
        checks++;
        if (daddr_out !== 7'h0 || di_out !== 16'h0) begin
            failures++;
            $display("FAIL reset_addr_data: got daddr=%h di=%h expected 0", daddr_out, di_out);
        end
        checks++;
        if (ch_data !== '0 || ch_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_ch: got ch_data=%h ch_idx=%0d expected 0", ch_data, ch_idx);
        end
        reset = 1'b0;
        clear_logs();
        tick(5);
        checks++;
        if (den_log.size() + val_log.size() + done_log.size() + ack_log.size() !== 0) begin
            failures++;
            $display("FAIL reset_idle_quiet: got %0d events expected 0",
                     den_log.size() + val_log.size() + done_log.size() + ack_log.size());
        end
        for (int i = 0; i < NUM_CH; i++) model_ch[i] = 16'h0;
    endtask

    task automatic test_sweep(input string name, input int lat);
        int t0;
        bit ok;
        fixed_lat = lat;
        randomize_mem();
        clear_logs();
        pulse_eoc(t0);
        wait_done(1, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_done_timeout: got none expected sweep_done", name); end
        checks++;
        if (den_log.size() !== NUM_CH || val_log.size() !== NUM_CH || done_log.size() !== 1) begin
            failures++;
            $display("FAIL %s_counts: got den=%0d valid=%0d done=%0d expected %0d/%0d/1",
                     name, den_log.size(), val_log.size(), done_log.size(), NUM_CH, NUM_CH);
        end else begin
            checks++;
            if (den_log[0].cyc !== t0 + 2) begin
                failures++;
                $display("FAIL %s_first_den: got cycle %0d expected %0d", name, den_log[0].cyc, t0 + 2);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                checks++;
                if (den_log[i].addr !== CH_BASE + 7'(i) || den_log[i].we !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_addr%0d: got %h we=%b expected %h we=0",
                             name, i, den_log[i].addr, den_log[i].we, CH_BASE + 7'(i));
                end
                checks++;
                if (val_log[i].idx !== i || val_log[i].data !== resp_mem[CH_BASE + 7'(i)]) begin
                    failures++;
                    $display("FAIL %s_valid%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                             name, i, val_log[i].idx, val_log[i].data, i, resp_mem[CH_BASE + 7'(i)]);
                end
                checks++;
                if (val_log[i].cyc !== den_log[i].cyc + den_log[i].lat + 1) begin
                    failures++;
                    $display("FAIL %s_valid_time%0d: got %0d expected %0d",
                             name, i, val_log[i].cyc, den_log[i].cyc + den_log[i].lat + 1);
                end
                if (i < NUM_CH - 1) begin
                    checks++;
                    if (den_log[i+1].cyc !== val_log[i].cyc) begin
                        failures++;
                        $display("FAIL %s_next_den%0d: got %0d expected %0d",
                                 name, i, den_log[i+1].cyc, val_log[i].cyc);
                    end
                end
                model_ch[i] = resp_mem[CH_BASE + 7'(i)];
            end
            checks++;
            if (done_log[0] !== val_log[NUM_CH-1].cyc) begin
                failures++;
                $display("FAIL %s_done_time: got %0d expected %0d", name, done_log[0], val_log[NUM_CH-1].cyc);
            end
        end
        checks++;
        if (ch_data !== model_vec() || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_ch_data: got %h terr=%b expected %h terr=0", name, ch_data, timeout_err, model_vec());
        end
    endtask

    task automatic test_write_priority();
        int  t0, budget;
        bit  ok;
        fixed_lat = 2;
        randomize_mem();
        clear_logs();
        t0      = cyc;
        wr_req  = 1'b1;
        wr_addr = XADC_CFG0_ADDR;
        wr_data = 16'h2000;
        eoc_in  = 1'b1;
        tick(1);
        eoc_in = 1'b0;
        budget = 0;
        while (!wr_ack && budget < 50) begin
            tick(1);
            budget++;
        end
        wr_req = 1'b0;
        checks++;
        if (!wr_ack) begin failures++; $display("FAIL wr_ack_timeout: got no wr_ack expected one"); end
        wait_done(1, 200, ok);
        tick(3);
        checks++;
        if (den_log.size() !== NUM_CH + 1 || ack_log.size() !== 1 || done_log.size() !== 1) begin
            failures++;
            $display("FAIL wr_counts: got den=%0d ack=%0d done=%0d expected %0d/1/1",
                     den_log.size(), ack_log.size(), done_log.size(), NUM_CH + 1);
        end else begin
            checks++;
            if (den_log[0].cyc !== t0 + 1 || den_log[0].we !== 1'b1 ||
                den_log[0].addr !== XADC_CFG0_ADDR || den_log[0].di !== 16'h2000) begin
                failures++;
                $display("FAIL wr_first: got cyc=%0d we=%b addr=%h di=%h expected cyc=%0d we=1 addr=40 di=2000",
                         den_log[0].cyc, den_log[0].we, den_log[0].addr, den_log[0].di, t0 + 1);
            end
            checks++;
            if (ack_log[0] !== den_log[0].cyc + den_log[0].lat + 1) begin
                failures++;
                $display("FAIL wr_ack_time: got %0d expected %0d", ack_log[0], den_log[0].cyc + den_log[0].lat + 1);
            end
            checks++;
            if (den_log[1].cyc !== ack_log[0] + 1 || den_log[1].addr !== CH_BASE || den_log[1].we !== 1'b0) begin
                failures++;
                $display("FAIL wr_then_sweep: got cyc=%0d addr=%h we=%b expected cyc=%0d addr=%h we=0",
                         den_log[1].cyc, den_log[1].addr, den_log[1].we, ack_log[0] + 1, CH_BASE);
            end
            for (int i = 0; i < NUM_CH; i++) model_ch[i] = resp_mem[CH_BASE + 7'(i)];
        end
        checks++;
        if (ch_data !== model_vec()) begin
            failures++;
            $display("FAIL wr_sweep_data: got %h expected %h", ch_data, model_vec());
        end
    endtask

    task automatic test_timeout();
        int t0;
        bit ok;
        fixed_lat   = 2;
        randomize_mem();
        silent_addr = CH_BASE + 7'd2;
        silent_en   = 1'b1;
        clear_logs();
        pulse_eoc(t0);
        wait_done(1, 300, ok);
        silent_en = 1'b0;
        checks++;
        if (den_log.size() !== NUM_CH || val_log.size() !== NUM_CH - 1 || done_log.size() !== 1) begin
            failures++;
            $display("FAIL to_counts: got den=%0d valid=%0d done=%0d expected %0d/%0d/1",
                     den_log.size(), val_log.size(), done_log.size(), NUM_CH, NUM_CH - 1);
        end else begin
            checks++;
            if (den_log[3].cyc - den_log[2].cyc !== TIMEOUT + 1) begin
                failures++;
                $display("FAIL to_gap: got %0d expected %0d", den_log[3].cyc - den_log[2].cyc, TIMEOUT + 1);
            end
            checks++;
            if (val_log[0].idx !== 0 || val_log[1].idx !== 1 || val_log[2].idx !== 3) begin
                failures++;
                $display("FAIL to_idx: got %0d,%0d,%0d expected 0,1,3", val_log[0].idx, val_log[1].idx, val_log[2].idx);
            end
            checks++;
            if (done_log[0] !== val_log[2].cyc) begin
                failures++;
                $display("FAIL to_done_time: got %0d expected %0d", done_log[0], val_log[2].cyc);
            end
        end
        model_ch[0] = resp_mem[CH_BASE];
        model_ch[1] = resp_mem[CH_BASE + 7'd1];
        model_ch[3] = resp_mem[CH_BASE + 7'd3];
        checks++;
        if (ch_data !== model_vec()) begin
            failures++;
            $display("FAIL to_ch_data: got %h expected %h", ch_data, model_vec());
        end
        checks++;
        if (timeout_err !== 1'b1 || overrun_err !== 1'b0) begin
            failures++;
            $display("FAIL to_flag: got terr=%b oerr=%b expected terr=1 oerr=0", timeout_err, overrun_err);
        end
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL to_clear: got %b expected 0", timeout_err);
        end
    endtask

    task automatic test_overrun();
        int t0, budget;
        bit ok;
        fixed_lat = 3;
        randomize_mem();
        clear_logs();
        pulse_eoc(t0);
        budget = 0;
        while (!den_out && budget < 20) begin
            tick(1);
            budget++;
        end
        tick(1);
        for (int k = 0; k < 2; k++) begin
            eoc_in = 1'b1;
            tick(1);
            eoc_in = 1'b0;
            tick(1);
        end
        wait_done(2, 300, ok);
        tick(20);
        checks++;
        if (!ok || den_log.size() !== 2 * NUM_CH || val_log.size() !== 2 * NUM_CH || done_log.size() !== 2) begin
            failures++;
            $display("FAIL ovr_counts: got den=%0d valid=%0d done=%0d expected %0d/%0d/2",
                     den_log.size(), val_log.size(), done_log.size(), 2 * NUM_CH, 2 * NUM_CH);
        end else begin
            checks++;
            if (den_log[NUM_CH].addr !== CH_BASE || val_log[NUM_CH].idx !== 0) begin
                failures++;
                $display("FAIL ovr_second_start: got addr=%h idx=%0d expected %h/0",
                         den_log[NUM_CH].addr, val_log[NUM_CH].idx, CH_BASE);
            end
        end
        for (int i = 0; i < NUM_CH; i++) model_ch[i] = resp_mem[CH_BASE + 7'(i)];
        checks++;
        if (overrun_err !== 1'b1 || ch_data !== model_vec()) begin
            failures++;
            $display("FAIL ovr_flag: got oerr=%b data=%h expected oerr=1 data=%h", overrun_err, ch_data, model_vec());
        end
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        checks++;
        if (overrun_err !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear: got %b expected 0", overrun_err);
        end
    endtask

    task automatic test_reset_mid();
        int  t0, budget;
        bit  found, ok;
        fixed_lat = 3;
        randomize_mem();
        clear_logs();
        pulse_eoc(t0);
        found  = 1'b0;
        budget = 0;
        while (!found && budget < 40) begin
            tick(1);
            budget++;
            if (den_out && daddr_out == CH_BASE + 7'd1) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rst_mid_find: got no ch1 read expected one"); end
        tick(1);
        eoc_in = 1'b1;
        tick(1);
        eoc_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({den_out, dwe_out, wr_ack, ch_valid, sweep_done, timeout_err, overrun_err} !== 7'b0 ||
            daddr_out !== 7'h0 || ch_idx !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got strobes=%b daddr=%h idx=%0d expected 0",
                     {den_out, dwe_out, wr_ack, ch_valid, sweep_done, timeout_err, overrun_err}, daddr_out, ch_idx);
        end
        checks++;
        if (ch_data !== '0) begin
            failures++;
            $display("FAIL rst_mid_ch_data: got %h expected 0", ch_data);
        end
        for (int i = 0; i < NUM_CH; i++) model_ch[i] = 16'h0;
        clear_logs();
        tick(1);
        reset = 1'b0;
        tick(15);
        checks++;
        if (den_log.size() + val_log.size() + done_log.size() + ack_log.size() !== 0) begin
            failures++;
            $display("FAIL rst_mid_stray: got den=%0d valid=%0d done=%0d ack=%0d expected none",
                     den_log.size(), val_log.size(), done_log.size(), ack_log.size());
        end
        pulse_eoc(t0);
        wait_done(1, 200, ok);
        checks++;
        if (!ok || den_log.size() !== NUM_CH || den_log[0].addr !== CH_BASE || den_log[0].cyc !== t0 + 2) begin
            failures++;
            $display("FAIL rst_mid_restart: got ok=%b den=%0d expected ch0 read at cycle %0d", ok, den_log.size(), t0 + 2);
        end
        for (int i = 0; i < NUM_CH; i++) model_ch[i] = resp_mem[CH_BASE + 7'(i)];
        checks++;
        if (ch_data !== model_vec()) begin
            failures++;
            $display("FAIL rst_mid_data: got %h expected %h", ch_data, model_vec());
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        bit ok;
        fixed_lat = 1;
        randomize_mem();
        clear_logs();
        pulse_eoc(t0);
        wait_done(1, 100, ok);
        checks++;
        if (!ok || den_log.size() !== NUM_CH) begin
            failures++;
            $display("FAIL b2b_counts: got ok=%b den=%0d expected 1/%0d", ok, den_log.size(), NUM_CH);
        end else begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
                checks++;
                if (den_log[i+1].cyc - den_log[i].cyc !== 2) begin
                    failures++;
                    $display("FAIL b2b_spacing%0d: got %0d expected 2", i, den_log[i+1].cyc - den_log[i].cyc);
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) model_ch[i] = resp_mem[CH_BASE + 7'(i)];
        tick(3);
        clear_logs();
        inject_drdy = 1'b1;
        tick(5);
        checks++;
        if (den_log.size() + val_log.size() + done_log.size() + ack_log.size() !== 0 || ch_data !== model_vec()) begin
            failures++;
            $display("FAIL idle_drdy: got events=%0d data=%h expected 0 events data=%h",
                     den_log.size() + val_log.size() + done_log.size() + ack_log.size(), ch_data, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_sweep("sweep", 3);
        for (int r = 0; r < 3; r++) test_sweep("sweep_rand", 0);
        test_write_priority();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
